tl_ul_reg_responder: RTL

TL_UL_REG_RESPONDER -- requirements
Module: tl_ul_reg_responder

---
 rtl/tl_ul_reg_responder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/tl_ul_reg_responder.sv
// TileLink-UL register responder: a byte-maskable word register file behind an
// A channel, with a small FIFO of D-channel responses.
module tl_ul_reg_responder #(
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [1:0]  a_size,
    input  logic [3:0]  a_source,
    input  logic [8:0]  a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    output logic        a_ready,
    output logic        d_valid,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [1:0]  d_size,
    output logic [3:0]  d_source,
    output logic        d_denied,
    output logic        d_corrupt,
    output logic [31:0] d_data,
    input  logic        d_ready
);

    localparam int unsigned WIDX       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PW         = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CW         = $clog2(RESP_DEPTH + 1);
    localparam int unsigned BYTE_LIMIT = 4 * NUM_WORDS;

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    // Byte lanes touched by an access of 2^size bytes at the given word offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << lo;
            2'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(RESP_DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    logic [31:0]     regs_q      [NUM_WORDS];
    logic [31:0]     regs_d      [NUM_WORDS];
    logic [2:0]      ent_op_q    [RESP_DEPTH];
    logic [2:0]      ent_op_d    [RESP_DEPTH];
    logic [1:0]      ent_size_q  [RESP_DEPTH];
    logic [1:0]      ent_size_d  [RESP_DEPTH];
    logic [3:0]      ent_src_q   [RESP_DEPTH];
    logic [3:0]      ent_src_d   [RESP_DEPTH];
    logic            ent_den_q   [RESP_DEPTH];
    logic            ent_den_d   [RESP_DEPTH];
    logic            ent_cor_q   [RESP_DEPTH];
    logic            ent_cor_d   [RESP_DEPTH];
    logic [31:0]     ent_data_q  [RESP_DEPTH];
    logic [31:0]     ent_data_d  [RESP_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            a_ready_q, a_ready_d;

    logic [3:0]      lane_s;
    logic            is_get_s;
    logic            is_put_s;
    logic            aligned_s;
    logic            in_range_s;
    logic            mask_ok_s;
    logic            legal_s;
    logic [WIDX-1:0] word_idx_s;
    logic            push_s;
    logic            pop_s;
    logic            d_valid_s;

    // Request decode and legality.
    always_comb begin
        lane_s     = lane_mask(a_size, a_address[1:0]);
        is_get_s   = (a_opcode == OP_GET);
        is_put_s   = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
        in_range_s = ({23'd0, a_address} < BYTE_LIMIT);
        word_idx_s = a_address[WIDX+1:2];
        case (a_size)
            2'd0:    aligned_s = 1'b1;
            2'd1:    aligned_s = (a_address[0] == 1'b0);
            2'd2:    aligned_s = (a_address[1:0] == 2'd0);
            default: aligned_s = 1'b0;
        endcase
        if (a_opcode == OP_PUT_FULL) begin
            mask_ok_s = (a_mask == lane_s);
        end else if (a_opcode == OP_PUT_PART) begin
            mask_ok_s = ((a_mask & ~lane_s) == 4'd0);
        end else begin
            mask_ok_s = 1'b1;
        end
        legal_s = (is_get_s || is_put_s) && (a_param == 3'd0) && aligned_s
                  && (a_size != 2'd3) && in_range_s && mask_ok_s;
    end

    assign d_valid_s = (count_q != CW'(0));
    assign push_s    = a_valid && a_ready_q;
    assign pop_s     = d_valid_s && d_ready;

    // Register file write path: only legal Puts touch the array, byte by byte.
    always_comb begin
        regs_d = regs_q;
        if (push_s && legal_s && is_put_s) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    regs_d[word_idx_s][8*b +: 8] = a_data[8*b +: 8];
                end else begin
                    regs_d[word_idx_s][8*b +: 8] = regs_q[word_idx_s][8*b +: 8];
                end
            end
        end else begin
            regs_d = regs_q;
        end
    end

    // Response queue: push captures Get data at acceptance so later writes cannot leak in.
    always_comb begin
        ent_op_d   = ent_op_q;
        ent_size_d = ent_size_q;
        ent_src_d  = ent_src_q;
        ent_den_d  = ent_den_q;
        ent_cor_d  = ent_cor_q;
        ent_data_d = ent_data_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (push_s) begin
            ent_op_d[wptr_q]   = is_get_s ? OP_ACK_DATA : OP_ACK;
            ent_size_d[wptr_q] = a_size;
            ent_src_d[wptr_q]  = a_source;
            ent_den_d[wptr_q]  = ~legal_s;
            ent_cor_d[wptr_q]  = ~legal_s && is_get_s;
            ent_data_d[wptr_q] = (legal_s && is_get_s) ? regs_q[word_idx_s] : 32'd0;
            wptr_d             = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        a_ready_d = (count_d < CW'(RESP_DEPTH));
    end

    // State registers; reset clears registers, queue and pending responses at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                regs_q[i] <= 32'd0;
            end
            for (int i = 0; i < int'(RESP_DEPTH); i++) begin
                ent_op_q[i]   <= 3'd0;
                ent_size_q[i] <= 2'd0;
                ent_src_q[i]  <= 4'd0;
                ent_den_q[i]  <= 1'b0;
                ent_cor_q[i]  <= 1'b0;
                ent_data_q[i] <= 32'd0;
            end
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            a_ready_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            ent_op_q   <= ent_op_d;
            ent_size_q <= ent_size_d;
            ent_src_q  <= ent_src_d;
            ent_den_q  <= ent_den_d;
            ent_cor_q  <= ent_cor_d;
            ent_data_q <= ent_data_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            a_ready_q  <= a_ready_d;
        end
    end

    assign a_ready   = a_ready_q;
    assign d_valid   = d_valid_s;
    assign d_param   = 2'd0;
    assign d_opcode  = d_valid_s ? ent_op_q[rptr_q]   : 3'd0;
    assign d_size    = d_valid_s ? ent_size_q[rptr_q] : 2'd0;
    assign d_source  = d_valid_s ? ent_src_q[rptr_q]  : 4'd0;
    assign d_denied  = d_valid_s ? ent_den_q[rptr_q]  : 1'b0;
    assign d_corrupt = d_valid_s ? ent_cor_q[rptr_q]  : 1'b0;
    assign d_data    = d_valid_s ? ent_data_q[rptr_q] : 32'd0;

endmodule
